// File: rtl/ti_pipe_out_arbiter_pkg.sv
// Shared definitions for the pipe-out arbiter: FSM state encodings and the
// layout of the ti_out_src wire-out word.
package ti_pipe_out_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_READY = 3'd2,
        ST_BURST = 3'd3,
        ST_HOLD  = 3'd4
    } arb_state_e;

    // ti_out_src layout: {valid, 12'b0, index[2:0]}
    localparam int SRC_VALID_BIT = 15;
    localparam int SRC_IDX_W     = 3;

    // Build the ti_out_src wire-out word from its fields.
    function automatic logic [15:0] make_src_word(input logic valid, input logic [SRC_IDX_W-1:0] idx);
        logic [15:0] w;
        w                  = '0;
        w[SRC_VALID_BIT]   = valid;
        w[SRC_IDX_W-1:0]   = idx;
        return w;
    endfunction

endpackage

// File: rtl/ti_pipe_out_arbiter_rr_select.sv
// Round-robin picker: first asserted request at or after start_i, wrapping
// modulo NUM_SRC. Purely combinational.
module rr_select #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 3
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   start_i,
    output logic               hit_o,
    output logic [SRC_W-1:0]   idx_o
);

    logic [SRC_W:0] pos;

    // Walk the rotated order; the first requester found wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = {1'b0, start_i} + (SRC_W+1)'(k);
            if (pos >= (SRC_W+1)'(NUM_SRC)) begin
                pos = pos - (SRC_W+1)'(NUM_SRC);
            end
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!hit_o && (pos == (SRC_W+1)'(j)) && req_i[j]) begin
                    hit_o = 1'b1;
                    idx_o = SRC_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/ti_pipe_out_arbiter.sv
// Pipe-out arbiter: grants whole BLOCK_LEN-word blocks from NUM_SRC buffered
// streams to one host pipe-out endpoint, in round-robin order.
module ti_pipe_out_arbiter
    import ti_pipe_out_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int BLOCK_LEN = 256,
    parameter int SRC_W     = 3
) (
    input  logic                    ti_clk,
    input  logic                    ti_rst_n,
    input  logic                    ti_arb_enable,
    input  logic [16*NUM_SRC-1:0]   src_available,
    output logic [NUM_SRC-1:0]      src_data_en,
    input  logic [16*NUM_SRC-1:0]   src_data,
    input  logic                    ti_out_data_en,
    output logic [15:0]             ti_out_data,
    output logic [15:0]             ti_out_available,
    output logic [15:0]             ti_out_src,
    output logic                    ti_overrun
);

    arb_state_e         state_q;
    logic [SRC_W-1:0]   grant_q;
    logic [SRC_W-1:0]   last_grant_q;
    logic [15:0]        word_cnt_q;
    logic [15:0]        word_cnt_d;
    logic [15:0]        avail_q;
    logic [15:0]        src_word_q;
    logic               overrun_q;
    logic               rst_meta_q;
    logic               rst_sync_q;

    logic [NUM_SRC-1:0] eligible;
    logic [15:0]        src_word [NUM_SRC];
    logic [SRC_W-1:0]   rr_start;
    logic               rr_hit;
    logic [SRC_W-1:0]   rr_idx;
    logic               in_block;
    logic               grant_held;
    logic [15:0]        out_word;

    // Reset asserts immediately, releases two ti_clk edges later.
    always_ff @(posedge ti_clk or negedge ti_rst_n) begin
        if (!ti_rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_word[gi]    = src_data[gi*16 +: 16];
            assign eligible[gi]    = src_available[gi*16 +: 16] >= 16'(BLOCK_LEN);
            assign src_data_en[gi] = in_block && (grant_q == SRC_W'(gi)) && ti_out_data_en;
        end
    endgenerate

    assign in_block   = (state_q == ST_READY) || (state_q == ST_BURST);
    assign grant_held = in_block || (state_q == ST_HOLD);
    assign rr_start   = (last_grant_q == SRC_W'(NUM_SRC-1)) ? '0 : last_grant_q + SRC_W'(1);
    assign word_cnt_d = word_cnt_q + 16'd1;

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_select (
        .req_i   (eligible),
        .start_i (rr_start),
        .hit_o   (rr_hit),
        .idx_o   (rr_idx)
    );

    // Route the granted source's data out; zero when no grant is held.
    always_comb begin
        out_word = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant_held && (grant_q == SRC_W'(j))) begin
                out_word = src_word[j];
            end
        end
    end

    assign ti_out_data      = out_word;
    assign ti_out_available = avail_q;
    assign ti_out_src       = src_word_q;
    assign ti_overrun       = overrun_q;

    // Arbitration FSM with registered wire-out words and overrun flag.
    always_ff @(posedge ti_clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_SRC-1);
            word_cnt_q   <= '0;
            avail_q      <= '0;
            src_word_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // A host strobe with no block on offer is a sticky error.
            if (ti_out_data_en && !in_block) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (ti_arb_enable) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (rr_hit) begin
                        grant_q    <= rr_idx;
                        word_cnt_q <= '0;
                        avail_q    <= 16'(BLOCK_LEN);
                        src_word_q <= make_src_word(1'b1, SRC_IDX_W'(rr_idx));
                        state_q    <= ST_READY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_READY, ST_BURST: begin
                    // Enable is deliberately ignored here: a block always completes.
                    if (ti_out_data_en) begin
                        word_cnt_q <= word_cnt_d;
                        if (word_cnt_d == 16'(BLOCK_LEN)) begin
                            avail_q <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_BURST;
                        end
                    end
                end
                ST_HOLD: begin
                    // Grant kept one more cycle so the final word reaches the host.
                    last_grant_q <= grant_q;
                    src_word_q   <= '0;
                    state_q      <= ti_arb_enable ? ST_SCAN : ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
